// File: rtl/issue_ctrl_pkg.sv
// Shared issue-stage types: execution unit indices, long-latency mask, flush states.
package issue_ctrl_pkg;

    localparam int NB_UNIT  = 4;
    localparam int UNIT_ALU = 0;
    localparam int UNIT_BRU = 1;
    localparam int UNIT_LSU = 2;
    localparam int UNIT_MUL = 3;

    localparam logic [NB_UNIT-1:0] LONG_LAT_MASK =
        NB_UNIT'((1 << UNIT_LSU) | (1 << UNIT_MUL));

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_FLUSH      = 2'd1,
        ST_FLUSH_DLY1 = 2'd2
    } flush_state_t;

    function automatic logic is_long_lat(input logic [NB_UNIT-1:0] unit);
        return |(unit & LONG_LAT_MASK);
    endfunction

endpackage

// File: rtl/issue_ctrl_scoreboard.sv
// Per-register pending-write bits; set wins over a same-cycle clear.
module scoreboard (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        i_set_v,
    input  logic [4:0]  i_set_adr,
    input  logic        i_clr_v,
    input  logic [4:0]  i_clr_adr,
    output logic [31:0] o_pending
);

    logic [31:1] r_pend;
    logic [31:0] w_set;
    logic [31:0] w_clr;
    logic [31:0] w_next;

    always_comb begin
        w_set  = i_set_v ? (32'd1 << i_set_adr) : 32'd0;
        w_clr  = i_clr_v ? (32'd1 << i_clr_adr) : 32'd0;
        w_next = ({r_pend, 1'b0} & ~w_clr) | w_set;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_pend <= '0;
        end else begin
            r_pend <= w_next[31:1];
        end
    end

    // x0 is never written, so its bit is hardwired clear
    assign o_pending = {r_pend, 1'b0};

endmodule

// File: rtl/issue_ctrl.sv
// Decode-to-execute issue control: RAW/WAW hazard check, flush sequencing,
// stall statistics.
module issue_ctrl
    import issue_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               reset_n,
    input  logic               dec_instr_v_i,
    input  logic               dec_rs1_v_i,
    input  logic [4:0]         dec_rs1_adr_i,
    input  logic               dec_rs2_v_i,
    input  logic [4:0]         dec_rs2_adr_i,
    input  logic               dec_rd_v_i,
    input  logic [4:0]         dec_rd_adr_i,
    input  logic [NB_UNIT-1:0] dec_unit_i,
    input  logic               exe_ready_i,
    input  logic               wb_v_i,
    input  logic [4:0]         wb_rd_adr_i,
    input  logic               branch_flush_i,
    output logic               dec_stall_o,
    output logic               issue_v_o,
    output logic               flush_v_q_o,
    output logic               flush_v_q_dly1_o,
    output logic [31:0]        sb_pending_o,
    output logic [15:0]        stall_cnt_o
);

    flush_state_t r_state;
    flush_state_t w_state_nxt;
    logic [15:0]  r_stall_cnt;
    logic [31:0]  w_pending;
    logic [31:0]  w_wb_mask;
    logic [31:0]  w_busy;
    logic         w_hazard;
    logic         w_flush_act;
    logic         w_stall;
    logic         w_issue;
    logic         w_sb_set;

    scoreboard u_sb (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_set_v   (w_sb_set),
        .i_set_adr (dec_rd_adr_i),
        .i_clr_v   (wb_v_i),
        .i_clr_adr (wb_rd_adr_i),
        .o_pending (w_pending)
    );

    // A register being written back this cycle is forwarded by the RF
    always_comb begin
        w_wb_mask   = wb_v_i ? (32'd1 << wb_rd_adr_i) : 32'd0;
        w_busy      = w_pending & ~w_wb_mask;
        w_hazard    = dec_instr_v_i &
                      ((dec_rs1_v_i & w_busy[dec_rs1_adr_i]) |
                       (dec_rs2_v_i & w_busy[dec_rs2_adr_i]) |
                       (dec_rd_v_i  & w_busy[dec_rd_adr_i]));
        w_flush_act = branch_flush_i | (r_state != ST_IDLE);
        w_stall     = dec_instr_v_i & (w_hazard | ~exe_ready_i) & ~w_flush_act;
        w_issue     = dec_instr_v_i & ~w_stall & ~w_flush_act;
        w_sb_set    = w_issue & dec_rd_v_i & (dec_rd_adr_i != 5'd0) &
                      is_long_lat(dec_unit_i);
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE:       w_state_nxt = branch_flush_i ? ST_FLUSH : ST_IDLE;
            ST_FLUSH:      w_state_nxt = ST_FLUSH_DLY1;
            ST_FLUSH_DLY1: w_state_nxt = branch_flush_i ? ST_FLUSH : ST_IDLE;
            default:       w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_stall_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_stall && (r_stall_cnt != 16'hFFFF)) begin
                r_stall_cnt <= r_stall_cnt + 16'd1;
            end
        end
    end

    assign dec_stall_o      = w_stall;
    assign issue_v_o        = w_issue;
    assign flush_v_q_o      = (r_state == ST_FLUSH);
    assign flush_v_q_dly1_o = (r_state == ST_FLUSH_DLY1);
    assign sb_pending_o     = w_pending;
    assign stall_cnt_o      = r_stall_cnt;

endmodule

// File: tb/tb_issue_ctrl.sv
// Bench for issue_ctrl: directed vector table, flush/reset sequences,
// randomized run against a reference model, counter saturation.
module tb_issue_ctrl;
    import issue_ctrl_pkg::*;

    typedef struct {
        logic       iv;
        logic       r1v;
        logic [4:0] r1;
        logic       r2v;
        logic [4:0] r2;
        logic       rdv;
        logic [4:0] rd;
        logic [3:0] unit;
        logic       rdy;
        logic       wbv;
        logic [4:0] wba;
        logic       br;
    } in_t;

    typedef struct {
        in_t         i;
        logic        est;
        logic        eis;
        logic [31:0] esb;
    } vec_t;

    localparam logic [3:0] U_ALU = 4'b0001;
    localparam logic [3:0] U_LSU = 4'b0100;
    localparam logic [3:0] U_MUL = 4'b1000;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        dec_instr_v_i, dec_rs1_v_i, dec_rs2_v_i, dec_rd_v_i;
    logic [4:0]  dec_rs1_adr_i, dec_rs2_adr_i, dec_rd_adr_i;
    logic [3:0]  dec_unit_i;
    logic        exe_ready_i, wb_v_i, branch_flush_i;
    logic [4:0]  wb_rd_adr_i;
    logic        dec_stall_o, issue_v_o, flush_v_q_o, flush_v_q_dly1_o;
    logic [31:0] sb_pending_o;
    logic [15:0] stall_cnt_o;

    int n_chk  = 0;
    int n_fail = 0;

    bit m_pend[32];
    int m_fl;
    int m_cnt;

    vec_t tbl[15];

    always #5 clk = ~clk;

    issue_ctrl dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .dec_instr_v_i    (dec_instr_v_i),
        .dec_rs1_v_i      (dec_rs1_v_i),
        .dec_rs1_adr_i    (dec_rs1_adr_i),
        .dec_rs2_v_i      (dec_rs2_v_i),
        .dec_rs2_adr_i    (dec_rs2_adr_i),
        .dec_rd_v_i       (dec_rd_v_i),
        .dec_rd_adr_i     (dec_rd_adr_i),
        .dec_unit_i       (dec_unit_i),
        .exe_ready_i      (exe_ready_i),
        .wb_v_i           (wb_v_i),
        .wb_rd_adr_i      (wb_rd_adr_i),
        .branch_flush_i   (branch_flush_i),
        .dec_stall_o      (dec_stall_o),
        .issue_v_o        (issue_v_o),
        .flush_v_q_o      (flush_v_q_o),
        .flush_v_q_dly1_o (flush_v_q_dly1_o),
        .sb_pending_o     (sb_pending_o),
        .stall_cnt_o      (stall_cnt_o)
    );

    function automatic in_t mk(input logic iv, input logic r1v,
                               input logic [4:0] r1, input logic r2v,
                               input logic [4:0] r2, input logic rdv,
                               input logic [4:0] rd, input logic [3:0] unit,
                               input logic rdy, input logic wbv,
                               input logic [4:0] wba, input logic br);
        in_t x;
        x.iv = iv; x.r1v = r1v; x.r1 = r1; x.r2v = r2v; x.r2 = r2;
        x.rdv = rdv; x.rd = rd; x.unit = unit; x.rdy = rdy;
        x.wbv = wbv; x.wba = wba; x.br = br;
        return x;
    endfunction

    function automatic vec_t mv(input in_t x, input logic est,
                                input logic eis, input logic [31:0] esb);
        vec_t v;
        v.i = x; v.est = est; v.eis = eis; v.esb = esb;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic apply(input in_t x);
        @(negedge clk);
        dec_instr_v_i  = x.iv;
        dec_rs1_v_i    = x.r1v;
        dec_rs1_adr_i  = x.r1;
        dec_rs2_v_i    = x.r2v;
        dec_rs2_adr_i  = x.r2;
        dec_rd_v_i     = x.rdv;
        dec_rd_adr_i   = x.rd;
        dec_unit_i     = x.unit;
        exe_ready_i    = x.rdy;
        wb_v_i         = x.wbv;
        wb_rd_adr_i    = x.wba;
        branch_flush_i = x.br;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        apply(mk(0, 0, 0, 0, 0, 0, 0, U_ALU, 1, 0, 0, 0));
    endtask

    task automatic do_reset();
        idle();
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        foreach (m_pend[k]) m_pend[k] = 1'b0;
        m_fl  = 0;
        m_cnt = 0;
    endtask

    function automatic logic [31:0] model_sb();
        logic [31:0] v;
        v = '0;
        for (int k = 0; k < 32; k++) v[k] = m_pend[k];
        return v;
    endfunction

    task automatic rand_cycle();
        in_t  x;
        logic fa, haz, est, eis;
        x = mk($urandom_range(0, 9) < 8, $urandom_range(0, 1),
               5'($urandom_range(0, 7)), $urandom_range(0, 1),
               5'($urandom_range(0, 7)), $urandom_range(0, 1),
               5'($urandom_range(0, 7)), 4'(1 << $urandom_range(0, 3)),
               $urandom_range(0, 9) < 8, $urandom_range(0, 9) < 3,
               5'($urandom_range(0, 7)), $urandom_range(0, 19) == 0);
        apply(x);
        haz = x.iv && ((x.r1v && m_pend[x.r1] && !(x.wbv && x.wba == x.r1)) ||
                       (x.r2v && m_pend[x.r2] && !(x.wbv && x.wba == x.r2)) ||
                       (x.rdv && m_pend[x.rd] && !(x.wbv && x.wba == x.rd)));
        fa  = x.br || (m_fl != 0);
        est = x.iv && (haz || !x.rdy) && !fa;
        eis = x.iv && !est && !fa;
        chk("rnd_stall", 32'(dec_stall_o), 32'(est));
        chk("rnd_issue", 32'(issue_v_o), 32'(eis));
        tick();
        if (x.wbv) m_pend[x.wba] = 1'b0;
        if (eis && x.rdv && x.rd != 0 && (x.unit == U_LSU || x.unit == U_MUL))
            m_pend[x.rd] = 1'b1;
        if (m_fl == 2)  m_fl = 1;
        else if (x.br)  m_fl = 2;
        else            m_fl = 0;
        if (est && m_cnt < 65535) m_cnt++;
        chk("rnd_sb", sb_pending_o, model_sb());
        chk("rnd_fq", 32'(flush_v_q_o), 32'(m_fl == 2));
        chk("rnd_fd", 32'(flush_v_q_dly1_o), 32'(m_fl == 1));
        chk("rnd_cnt", 32'(stall_cnt_o), 32'(m_cnt));
    endtask

    initial begin
        reset_n = 1'b0;
        tbl[0]  = mv(mk(1, 0, 0, 0, 0, 1, 5, U_LSU, 1, 0, 0, 0), 0, 1, 32'h20);
        tbl[1]  = mv(mk(1, 1, 5, 1, 1, 1, 6, U_ALU, 1, 0, 0, 0), 1, 0, 32'h20);
        tbl[2]  = mv(mk(1, 1, 5, 1, 1, 1, 6, U_ALU, 1, 0, 0, 0), 1, 0, 32'h20);
        tbl[3]  = mv(mk(1, 1, 5, 1, 1, 1, 6, U_ALU, 1, 1, 5, 0), 0, 1, 32'h0);
        tbl[4]  = mv(mk(1, 0, 0, 0, 0, 1, 0, U_LSU, 1, 0, 0, 0), 0, 1, 32'h0);
        tbl[5]  = mv(mk(1, 1, 0, 0, 0, 1, 8, U_ALU, 1, 0, 0, 0), 0, 1, 32'h0);
        tbl[6]  = mv(mk(1, 0, 0, 0, 0, 1, 7, U_MUL, 1, 0, 0, 0), 0, 1, 32'h80);
        tbl[7]  = mv(mk(1, 0, 0, 0, 0, 1, 7, U_LSU, 1, 1, 7, 0), 0, 1, 32'h80);
        tbl[8]  = mv(mk(1, 0, 0, 0, 0, 1, 1, U_ALU, 0, 0, 0, 0), 1, 0, 32'h80);
        tbl[9]  = mv(mk(0, 0, 0, 0, 0, 0, 0, U_ALU, 1, 1, 3, 0), 0, 0, 32'h80);
        tbl[10] = mv(mk(0, 0, 0, 0, 0, 0, 0, U_ALU, 1, 1, 7, 0), 0, 0, 32'h0);
        tbl[11] = mv(mk(1, 0, 0, 0, 0, 1, 9, U_LSU, 1, 0, 0, 0), 0, 1, 32'h200);
        tbl[12] = mv(mk(1, 0, 0, 1, 9, 1, 10, U_ALU, 1, 0, 0, 0), 1, 0, 32'h200);
        tbl[13] = mv(mk(1, 0, 0, 0, 0, 1, 9, U_ALU, 1, 0, 0, 0), 1, 0, 32'h200);
        tbl[14] = mv(mk(0, 0, 0, 0, 0, 0, 0, U_ALU, 1, 1, 9, 0), 0, 0, 32'h0);

        // reset values and combinational outputs during reset
        do_reset();
        reset_n = 1'b0;
        apply(mk(1, 0, 0, 0, 0, 0, 0, U_ALU, 0, 0, 0, 0));
        chk("rst_stall_comb", 32'(dec_stall_o), 32'd1);
        tick();
        chk("rst_sb", sb_pending_o, 32'd0);
        chk("rst_cnt", 32'(stall_cnt_o), 32'd0);
        chk("rst_fq", 32'(flush_v_q_o), 32'd0);
        chk("rst_fd", 32'(flush_v_q_dly1_o), 32'd0);
        reset_n = 1'b1;
        idle();
        tick();

        // directed vector table
        for (int i = 0; i < 15; i++) begin
            apply(tbl[i].i);
            chk($sformatf("tbl%0d_stall", i), 32'(dec_stall_o), 32'(tbl[i].est));
            chk($sformatf("tbl%0d_issue", i), 32'(issue_v_o), 32'(tbl[i].eis));
            tick();
            chk($sformatf("tbl%0d_sb", i), sb_pending_o, tbl[i].esb);
        end
        chk("tbl_cnt", 32'(stall_cnt_o), 32'd5);

        // flush sequence with re-flush from FLUSH_DLY1 and ignored flush in FLUSH
        apply(mk(1, 0, 0, 0, 0, 0, 0, U_ALU, 1, 0, 0, 1));
        chk("fl_t_issue", 32'(issue_v_o), 32'd0);
        chk("fl_t_stall", 32'(dec_stall_o), 32'd0);
        tick();
        chk("fl_t1_fq", 32'(flush_v_q_o), 32'd1);
        apply(mk(1, 0, 0, 0, 0, 0, 0, U_ALU, 1, 0, 0, 0));
        chk("fl_t1_issue", 32'(issue_v_o), 32'd0);
        tick();
        chk("fl_t2_fd", 32'(flush_v_q_dly1_o), 32'd1);
        chk("fl_t2_fq", 32'(flush_v_q_o), 32'd0);
        apply(mk(1, 0, 0, 0, 0, 0, 0, U_ALU, 1, 0, 0, 1));
        chk("fl_t2_issue", 32'(issue_v_o), 32'd0);
        tick();
        chk("fl_t3_fq", 32'(flush_v_q_o), 32'd1);
        apply(mk(1, 0, 0, 0, 0, 0, 0, U_ALU, 1, 0, 0, 1));
        tick();
        chk("fl_t4_fd", 32'(flush_v_q_dly1_o), 32'd1);
        chk("fl_t4_fq", 32'(flush_v_q_o), 32'd0);
        apply(mk(1, 0, 0, 0, 0, 0, 0, U_ALU, 1, 0, 0, 0));
        tick();
        chk("fl_t5_fq", 32'(flush_v_q_o), 32'd0);
        chk("fl_t5_fd", 32'(flush_v_q_dly1_o), 32'd0);
        chk("fl_t5_issue", 32'(issue_v_o), 32'd1);

        // reset during FLUSH with x3 pending
        apply(mk(1, 0, 0, 0, 0, 1, 3, U_LSU, 1, 0, 0, 0));
        tick();
        chk("rf_sb3", sb_pending_o, 32'h8);
        apply(mk(0, 0, 0, 0, 0, 0, 0, U_ALU, 1, 0, 0, 1));
        tick();
        chk("rf_in_flush", 32'(flush_v_q_o), 32'd1);
        chk("rf_flush_keeps_sb", sb_pending_o, 32'h8);
        idle();
        reset_n = 1'b0;
        tick();
        chk("rf_fq", 32'(flush_v_q_o), 32'd0);
        chk("rf_fd", 32'(flush_v_q_dly1_o), 32'd0);
        chk("rf_sb", sb_pending_o, 32'd0);
        chk("rf_cnt", 32'(stall_cnt_o), 32'd0);
        chk("rf_stall", 32'(dec_stall_o), 32'd0);
        chk("rf_issue", 32'(issue_v_o), 32'd0);
        reset_n = 1'b1;
        apply(mk(1, 0, 0, 0, 0, 0, 0, U_ALU, 1, 0, 0, 0));
        chk("rf_idle_issue", 32'(issue_v_o), 32'd1);
        tick();

        // randomized run against the reference model
        do_reset();
        for (int i = 0; i < 3000; i++) rand_cycle();

        // stall counter saturation
        do_reset();
        apply(mk(1, 0, 0, 0, 0, 0, 0, U_ALU, 0, 0, 0, 0));
        for (int i = 0; i < 65534; i++) @(posedge clk);
        #1;
        chk("sat_near", 32'(stall_cnt_o), 32'hFFFE);
        for (int i = 0; i < 4466; i++) @(posedge clk);
        #1;
        chk("sat_cnt", 32'(stall_cnt_o), 32'hFFFF);
        chk("sat_stall", 32'(dec_stall_o), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/issue_ctrl.md
ISSUE_CTRL -- requirements
Module: issue_ctrl

Interface
REQ-001 clk  in  1  single core clock; all state updates on rising edge.
REQ-002 reset_n  in  1  reset, synchronous, active-low.
REQ-003 dec_instr_v_i  in  1  decode holds a valid instruction this cycle.
REQ-004 dec_rs1_v_i / dec_rs1_adr_i  in  1 / 5  rs1 read valid and address.
REQ-005 dec_rs2_v_i / dec_rs2_adr_i  in  1 / 5  rs2 read valid and address.
REQ-006 dec_rd_v_i / dec_rd_adr_i  in  1 / 5  rd write valid and address.
REQ-007 dec_unit_i  in  NB_UNIT  one-hot execution unit of the decoded instruction.
REQ-008 exe_ready_i  in  1  execute stage accepts an instruction this cycle.
REQ-009 wb_v_i / wb_rd_adr_i  in  1 / 5  long-latency (LSU/MUL) result written to RF this cycle.
REQ-010 branch_flush_i  in  1  redirect from execute; kills younger instructions.
REQ-011 dec_stall_o  out  1  hold ifetch/decode registers.
REQ-012 issue_v_o  out  1  instruction leaves decode this cycle.
REQ-013 flush_v_q_o / flush_v_q_dly1_o  out  1 / 1  flush sequence, cycle 1 and cycle 2.
REQ-014 sb_pending_o  out  32  scoreboard vector, bit n = write to xn outstanding.
REQ-015 stall_cnt_o  out  16  saturating count of stall cycles.

Function
REQ-016 Scoreboard SHALL hold one pending bit per register; bit 0 SHALL be constant 0.
REQ-017 On issue_v_o with dec_rd_v_i, rd!=0, and dec_unit_i in LONG_LAT_MASK, the rd bit SHALL set on the next edge.
REQ-018 On wb_v_i, the bit at wb_rd_adr_i SHALL clear on the next edge; simultaneous set and clear of the same bit SHALL leave it set.
REQ-019 A hazard SHALL exist if the instruction is valid and any of these holds for a pending bit not being cleared by wb_v_i this cycle: (rs1_v & sb[rs1]), (rs2_v & sb[rs2]), or (rd_v & sb[rd]) (WAW).
REQ-020 A same-cycle wb_v_i match SHALL remove the hazard for that register, since the RF fast-forward supplies the data.
REQ-021 dec_stall_o = dec_instr_v_i & (hazard | ~exe_ready_i) & ~flush_active; combinational, zero latency.
REQ-022 issue_v_o = dec_instr_v_i & ~dec_stall_o & ~flush_active, where flush_active = branch_flush_i | state!=IDLE.
REQ-023 Flush FSM states: IDLE, FLUSH, FLUSH_DLY1.
REQ-024 FSM transitions: IDLE->FLUSH on branch_flush_i; FLUSH->FLUSH_DLY1 unconditionally; FLUSH_DLY1->FLUSH on branch_flush_i, else ->IDLE; branch_flush_i in FLUSH SHALL be ignored.
REQ-025 flush_v_q_o = (state==FLUSH); flush_v_q_dly1_o = (state==FLUSH_DLY1); both registered, so each is high exactly one cycle per flush.
REQ-026 Flush SHALL NOT clear scoreboard bits; instructions already issued still write back.
REQ-027 stall_cnt_o SHALL increment on every cycle dec_stall_o=1 and saturate at 16'hFFFF.
REQ-028 A wb_v_i to a register whose bit is clear SHALL have no effect, and no error SHALL be flagged.

Reset
REQ-029 While reset_n=0 at an edge: scoreboard=0, state=IDLE, stall_cnt=0.
REQ-030 Reset values: flush outputs 0, sb_pending_o 0, stall_cnt_o 0; combinational outputs follow inputs.
REQ-031 Reset asserted mid-flush or with pending loads SHALL discard all state within one edge.

Structure
REQ-032 The shared riscv package SHALL hold the flush_state_t enum, LONG_LAT_MASK (LSU, MUL bits), NB_UNIT and the unit index constants.
REQ-033 The 32-entry set/clear register array SHALL be a natural single sub-module, scoreboard.
REQ-034 The FSM, hazard logic and counter SHALL live in issue_ctrl.

Verification
REQ-035 Load x5 issued, then add x6,x5,x1 -> stall 1+ cycles until wb_v_i/x5; issue_v_o in the wb cycle; sb_pending_o[5] 1->0.
REQ-036 Load to x0 -> sb_pending_o stays 0 and no stall on a following read of x0.
REQ-037 branch_flush_i at t -> flush_v_q_o=1 at t+1, flush_v_q_dly1_o=1 at t+2, issue_v_o=0 for t..t+2; second flush at t+2 -> flush_v_q_o=1 at t+3.
REQ-038 Same-cycle issue of load x7 and wb_v_i x7 -> sb_pending_o[7]=1 next cycle.
REQ-039 exe_ready_i=0 held 70000 cycles with valid instr -> stall_cnt_o=16'hFFFF, no wrap.
REQ-040 reset_n low during FLUSH with sb[3]=1 -> next cycle state IDLE, all outputs 0.
